round_ctrl: RTL and testbench
=============================

Name: round_ctrl

Overview:
- Per-round duck datapath sequencer that sits between the light-gun/video frontend and the core game FSM.
- Counts shots and frame-based flight and hit-window timers, decides each round's outcome, and tallies birds and score.
- Produces the status levels the game FSM consumes: no_shots_left, flew_away, bird_shot, game_over.
- Obeys the FSM's new_round / reset_shots / reset_score / reset_birds strobes.

Parameters:
- SHOTS, 3: shots loaded per round; must fit in shots_left (max 3).
- FLY_FRAMES, 300: frame ticks a duck stays on screen before escaping (5 s at 60 Hz).
- HIT_WIN_FRAMES, 2: frame ticks after a trigger during which hit is accepted.
- BIRDS_PER_GAME, 10: ducks per game; also the width of hit_mask.
- POINTS, 500: score added per duck hit.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- new_round  in  1  start a new duck (pulse or level; acted on every cycle it is high)
- reset_shots  in  1  reload shots_left to SHOTS
- reset_score  in  1  clear score
- reset_birds  in  1  clear birds_done, birds_hit, hit_mask
- trigger  in  1  one-cycle gun-fire pulse
- hit  in  1  light-sensor hit, valid only inside the hit window
- no_shots_left  out  1  round lost by exhausting shots
- flew_away  out  1  duck gone, not shot
- bird_shot  out  1  duck hit this round
- game_over  out  1  birds_done >= BIRDS_PER_GAME
- shots_left  out  2  remaining shots
- birds_done  out  4  ducks resolved this game
- birds_hit  out  4  ducks hit this game
- hit_mask  out  BIRDS_PER_GAME  bit i set when duck i was hit
- score  out  16  running score

Behaviour:
- Reset (sync, takes priority over everything):
  - State = IDLE; shots_left = SHOTS.
  - All counters, score, hit_mask and the fly/window timers = 0.
  - All status outputs = 0.
- States: IDLE, FLY, WINDOW, SHOT, GONE. All outputs are registered.
- new_round:
  - From any state except Reset, enter FLY.
  - Clear fly_cnt and win_cnt; set shots_left = SHOTS.
  - Dominates trigger, hit and frame_tick in the same cycle.
- IDLE: trigger and hit are ignored.
- FLY:
  - trigger with shots_left > 0: shots_left--, win_cnt = 0, go to WINDOW; fly_cnt is frozen while in WINDOW.
  - trigger with shots_left == 0: ignored.
  - frame_tick: fly_cnt++. If fly_cnt == FLY_FRAMES-1 on a tick, go to GONE and birds_done++.
  - trigger and timeout tick in the same cycle: trigger wins, no escape.
- WINDOW:
  - hit high in any cycle: go to SHOT; birds_done++, birds_hit++, hit_mask[birds_done] = 1.
  - Score on hit: score += POINTS, saturating at 16'hFFFF.
  - frame_tick: win_cnt++. When win_cnt reaches HIT_WIN_FRAMES with no hit:
    - shots_left > 0: return to FLY, fly_cnt resumes.
    - shots_left == 0: go to GONE, birds_done++.
  - hit and window expiry in the same cycle: hit wins.
  - Further triggers in WINDOW are ignored (no shot consumed).
- SHOT and GONE: hold until new_round or Reset; trigger and hit are ignored.
- Status outputs (levels, held until new_round or Reset):
  - bird_shot = (state == SHOT).
  - flew_away = (state == GONE).
  - no_shots_left = (state == GONE) && (shots_left == 0).
- Required output ordering:
  - A hit on the last shot gives bird_shot = 1, no_shots_left = 0.
  - A miss on the last shot gives no_shots_left = flew_away = 1 in the same cycle.
- game_over is registered as (birds_done >= BIRDS_PER_GAME).
- birds_done and birds_hit saturate at BIRDS_PER_GAME; hit_mask writes are dropped once birds_done >= BIRDS_PER_GAME.
- Clear strobes:
  - reset_shots: shots_left = SHOTS in any state, with no state change; a GONE state may then deassert no_shots_left, which is allowed.
  - reset_birds / reset_score beat a same-cycle increment, so the cleared value wins.
  - reset_birds also forces game_over low on the next cycle.
- Latency: every input event is visible on the outputs exactly 1 cycle after the input cycle.

Test Plan:
- Hit on the first shot: Reset, new_round, trigger, hit 1 cycle later.
  - Expect bird_shot = 1 the next cycle, shots_left = 2, score = 500, birds_hit = 1, hit_mask = 10'b1, no_shots_left = 0.
- Miss all shots: new_round, then 3 triggers, each followed by 2 frame_ticks with hit = 0.
  - Expect shots_left 3→2→1→0.
  - After the third window: flew_away = no_shots_left = 1, birds_done = 1, birds_hit = 0.
- Fly-away timeout: new_round, 300 frame_ticks, no trigger.
  - Expect flew_away = 1 exactly 1 cycle after tick 300, no_shots_left = 0, shots_left = 3.
  - Repeat with trigger on the cycle of tick 300: expect WINDOW, not GONE.
- Last-shot hit plus window expiry in the same cycle: shots_left = 0, with hit and the expiring frame_tick coincident.
  - Expect bird_shot = 1, flew_away = 0, no_shots_left = 0.
- Full game: 10 rounds, each ending with a hit.
  - Expect game_over = 1 after the 10th, score = 5000, hit_mask = 10'h3FF.
  - Then assert reset_birds and reset_score: expect zeros and game_over = 0 the next cycle.
- Reset mid-WINDOW:
  - Expect IDLE, all outputs zero, shots_left = 3.
  - A following trigger is ignored until new_round.

Source files
------------

// File: rtl/round_ctrl.sv
// ---------------------------------------------------------------------------
// round_ctrl
//
// Per-round duck sequencer sitting between the light-gun/video frontend and
// the core game FSM. It counts shots, runs the frame-based flight timer and
// the post-trigger hit window, decides how each round ends, and keeps the
// per-game bird tally, hit mask and score.
//
// Ports
//   Clk            system clock
//   Reset          synchronous, active-high reset (highest priority)
//   frame_tick     one-cycle pulse per video frame
//   new_round      start a new duck (acted on every cycle it is high)
//   reset_shots    reload shots_left to SHOTS, no state change
//   reset_score    clear score
//   reset_birds    clear birds_done, birds_hit, hit_mask (and game_over)
//   trigger        one-cycle gun-fire pulse
//   hit            light-sensor hit, only meaningful inside the hit window
//   no_shots_left  round lost by running out of shots
//   flew_away      duck gone without being shot
//   bird_shot      duck hit this round
//   game_over      birds_done has reached BIRDS_PER_GAME
//   shots_left     remaining shots this round
//   birds_done     ducks resolved this game (saturating)
//   birds_hit      ducks hit this game (saturating)
//   hit_mask       bit i set when duck i was hit
//   score          running score (saturating at 16'hFFFF)
//
// Every output is a register, so any input event shows up exactly one cycle
// after the cycle it was presented.
// ---------------------------------------------------------------------------
module round_ctrl #(
    parameter int SHOTS          = 3,
    parameter int FLY_FRAMES     = 300,
    parameter int HIT_WIN_FRAMES = 2,
    parameter int BIRDS_PER_GAME = 10,
    parameter int POINTS         = 500
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_tick,
    input  logic                      new_round,
    input  logic                      reset_shots,
    input  logic                      reset_score,
    input  logic                      reset_birds,
    input  logic                      trigger,
    input  logic                      hit,
    output logic                      no_shots_left,
    output logic                      flew_away,
    output logic                      bird_shot,
    output logic                      game_over,
    output logic [1:0]                shots_left,
    output logic [3:0]                birds_done,
    output logic [3:0]                birds_hit,
    output logic [BIRDS_PER_GAME-1:0] hit_mask,
    output logic [15:0]               score
);

    localparam int FLY_W = $clog2(FLY_FRAMES + 1);
    localparam int WIN_W = $clog2(HIT_WIN_FRAMES + 1);

    localparam logic [1:0]       SHOTS_V   = 2'(SHOTS);
    localparam logic [3:0]       BIRDS_MAX = 4'(BIRDS_PER_GAME);
    localparam logic [FLY_W-1:0] FLY_LAST  = FLY_W'(FLY_FRAMES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(HIT_WIN_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FLY,
        WINDOW,
        SHOT,
        GONE
    } state_t;

    state_t           state;
    logic [FLY_W-1:0] fly_cnt;
    logic [WIN_W-1:0] win_cnt;

    logic                      birds_full;
    logic [3:0]                birds_done_inc;
    logic [3:0]                birds_hit_inc;
    logic                      game_over_inc;
    logic [BIRDS_PER_GAME-1:0] hit_mask_inc;
    logic [16:0]               score_sum;
    logic [15:0]               score_inc;
    logic                      fly_timeout;
    logic                      win_expire;

    // Saturating "one more duck" values, shared by every path that resolves
    // a round. Once the game is full the mask stops taking new bits.
    assign birds_full     = (birds_done >= BIRDS_MAX);
    assign birds_done_inc = birds_full ? birds_done : birds_done + 4'd1;
    assign birds_hit_inc  = (birds_hit >= BIRDS_MAX) ? birds_hit : birds_hit + 4'd1;
    assign game_over_inc  = (birds_done_inc >= BIRDS_MAX);
    assign hit_mask_inc   = birds_full ? hit_mask
                                       : (hit_mask | (BIRDS_PER_GAME'(1) << birds_done));

    // Score add is done one bit wider so the carry tells us to clamp.
    assign score_sum = {1'b0, score} + 17'(POINTS);
    assign score_inc = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // Timer end conditions are checked on the tick that would complete the
    // count, so the transition lands right after the final tick.
    assign fly_timeout = (fly_cnt == FLY_LAST);
    assign win_expire  = (win_cnt == WIN_LAST);

    // Round FSM with all registered outputs. new_round overrides the per
    // state behaviour; the clear strobes are applied last so that a cleared
    // value beats any increment made in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            fly_cnt       <= '0;
            win_cnt       <= '0;
            shots_left    <= SHOTS_V;
            birds_done    <= '0;
            birds_hit     <= '0;
            hit_mask      <= '0;
            score         <= '0;
            no_shots_left <= 1'b0;
            flew_away     <= 1'b0;
            bird_shot     <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            if (new_round) begin
                state         <= FLY;
                fly_cnt       <= '0;
                win_cnt       <= '0;
                shots_left    <= SHOTS_V;
                no_shots_left <= 1'b0;
                flew_away     <= 1'b0;
                bird_shot     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end

                    FLY: begin
                        // A live trigger wins over a same-cycle timeout tick,
                        // and the flight timer is frozen while the window runs.
                        if (trigger && (shots_left != 2'd0)) begin
                            shots_left <= shots_left - 2'd1;
                            win_cnt    <= '0;
                            state      <= WINDOW;
                        end else if (frame_tick) begin
                            if (fly_timeout) begin
                                state         <= GONE;
                                flew_away     <= 1'b1;
                                no_shots_left <= (shots_left == 2'd0);
                                birds_done    <= birds_done_inc;
                                game_over     <= game_over_inc;
                            end else begin
                                fly_cnt <= fly_cnt + 1'b1;
                            end
                        end
                    end

                    WINDOW: begin
                        // A hit in the expiring cycle still counts.
                        if (hit) begin
                            state      <= SHOT;
                            bird_shot  <= 1'b1;
                            birds_done <= birds_done_inc;
                            birds_hit  <= birds_hit_inc;
                            hit_mask   <= hit_mask_inc;
                            score      <= score_inc;
                            game_over  <= game_over_inc;
                        end else if (frame_tick) begin
                            if (win_expire) begin
                                if (shots_left != 2'd0) begin
                                    state <= FLY;
                                end else begin
                                    state         <= GONE;
                                    flew_away     <= 1'b1;
                                    no_shots_left <= 1'b1;
                                    birds_done    <= birds_done_inc;
                                    game_over     <= game_over_inc;
                                end
                            end else begin
                                win_cnt <= win_cnt + 1'b1;
                            end
                        end
                    end

                    SHOT, GONE: begin
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end

            // A reload always leaves shots available, so a GONE round stops
            // reporting "no shots left" once the shots come back.
            if (reset_shots) begin
                shots_left    <= SHOTS_V;
                no_shots_left <= 1'b0;
            end

            if (reset_score) begin
                score <= '0;
            end

            if (reset_birds) begin
                birds_done <= '0;
                birds_hit  <= '0;
                hit_mask   <= '0;
                game_over  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_round_ctrl
//
// Self-checking bench for round_ctrl. A table of {inputs, expected outputs}
// records covers the single-round behaviour; hand-written loops cover the
// long flight timeout and a full ten-duck game. Expected outputs are pushed
// onto a scoreboard queue as each stimulus is driven and popped when the
// DUT's registered outputs are sampled one cycle later.
// ---------------------------------------------------------------------------
module tb_round_ctrl;

    // Input bit positions inside a stimulus word
    localparam int I_RST  = 0;
    localparam int I_NR   = 1;
    localparam int I_RSH  = 2;
    localparam int I_RSC  = 3;
    localparam int I_RB   = 4;
    localparam int I_TRIG = 5;
    localparam int I_HIT  = 6;
    localparam int I_TICK = 7;

    typedef struct {
        logic        nsl;
        logic        fa;
        logic        bs;
        logic        go;
        logic [1:0]  shots;
        logic [3:0]  bd;
        logic [3:0]  bh;
        logic [9:0]  mask;
        logic [15:0] score;
    } outs_t;

    typedef struct {
        logic [7:0] ins;
        outs_t      exp;
    } vec_t;

    logic        Clk;
    logic        Reset;
    logic        frame_tick;
    logic        new_round;
    logic        reset_shots;
    logic        reset_score;
    logic        reset_birds;
    logic        trigger;
    logic        hit;
    logic        no_shots_left;
    logic        flew_away;
    logic        bird_shot;
    logic        game_over;
    logic [1:0]  shots_left;
    logic [3:0]  birds_done;
    logic [3:0]  birds_hit;
    logic [9:0]  hit_mask;
    logic [15:0] score;

    int    errors;
    int    checks;
    outs_t sb[$];
    vec_t  tbl[$];

    round_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_tick    (frame_tick),
        .new_round     (new_round),
        .reset_shots   (reset_shots),
        .reset_score   (reset_score),
        .reset_birds   (reset_birds),
        .trigger       (trigger),
        .hit           (hit),
        .no_shots_left (no_shots_left),
        .flew_away     (flew_away),
        .bird_shot     (bird_shot),
        .game_over     (game_over),
        .shots_left    (shots_left),
        .birds_done    (birds_done),
        .birds_hit     (birds_hit),
        .hit_mask      (hit_mask),
        .score         (score)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Build an expected-output record
    function automatic outs_t o(input logic nsl, input logic fa, input logic bs,
                                input logic go, input logic [1:0] sh,
                                input logic [3:0] bd, input logic [3:0] bh,
                                input logic [9:0] m, input logic [15:0] sc);
        outs_t r;
        r.nsl   = nsl;
        r.fa    = fa;
        r.bs    = bs;
        r.go    = go;
        r.shots = sh;
        r.bd    = bd;
        r.bh    = bh;
        r.mask  = m;
        r.score = sc;
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] ins, input outs_t e);
        vec_t v;
        v.ins = ins;
        v.exp = e;
        return v;
    endfunction

    function automatic logic [7:0] bit_of(input int pos);
        logic [7:0] r;
        r = 8'd0;
        r[pos] = 1'b1;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs
    task automatic checkOutput(input string tag);
        outs_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".no_shots_left"}, 32'(no_shots_left), 32'(e.nsl));
            cmp({tag, ".flew_away"},     32'(flew_away),     32'(e.fa));
            cmp({tag, ".bird_shot"},     32'(bird_shot),     32'(e.bs));
            cmp({tag, ".game_over"},     32'(game_over),     32'(e.go));
            cmp({tag, ".shots_left"},    32'(shots_left),    32'(e.shots));
            cmp({tag, ".birds_done"},    32'(birds_done),    32'(e.bd));
            cmp({tag, ".birds_hit"},     32'(birds_hit),     32'(e.bh));
            cmp({tag, ".hit_mask"},      32'(hit_mask),      32'(e.mask));
            cmp({tag, ".score"},         32'(score),         32'(e.score));
        end
    endtask

    // Drive one cycle of inputs, optionally expecting a result next cycle
    task automatic applyStimulus(input logic [7:0] ins, input logic chk,
                                 input outs_t e, input string tag);
        Reset       = ins[I_RST];
        new_round   = ins[I_NR];
        reset_shots = ins[I_RSH];
        reset_score = ins[I_RSC];
        reset_birds = ins[I_RB];
        trigger     = ins[I_TRIG];
        hit         = ins[I_HIT];
        frame_tick  = ins[I_TICK];
        if (chk) sb.push_back(e);
        @(posedge Clk);
        #1;
        Reset       = 1'b0;
        new_round   = 1'b0;
        reset_shots = 1'b0;
        reset_score = 1'b0;
        reset_birds = 1'b0;
        trigger     = 1'b0;
        hit         = 1'b0;
        frame_tick  = 1'b0;
        if (chk) checkOutput(tag);
    endtask

    // Hard stop in case the bench ever stalls
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected normal end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0] RST, NR, RSH, RSC, RB, TRG, HIT, TCK;
        outs_t      e;

        errors      = 0;
        checks      = 0;
        Reset       = 1'b0;
        new_round   = 1'b0;
        reset_shots = 1'b0;
        reset_score = 1'b0;
        reset_birds = 1'b0;
        trigger     = 1'b0;
        hit         = 1'b0;
        frame_tick  = 1'b0;

        RST = bit_of(I_RST);
        NR  = bit_of(I_NR);
        RSH = bit_of(I_RSH);
        RSC = bit_of(I_RSC);
        RB  = bit_of(I_RB);
        TRG = bit_of(I_TRIG);
        HIT = bit_of(I_HIT);
        TCK = bit_of(I_TICK);

        // ---- single-round behaviour table ------------------------------
        //                    nsl fa bs go sh bd bh mask   score
        // reset and idle
        tbl.push_back(mk(RST,       o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0)));
        // hit on first shot
        tbl.push_back(mk(NR,        o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 2, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(HIT,       o(0, 0, 1, 0, 2, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TRG | HIT, o(0, 0, 1, 0, 2, 1, 1, 10'h001, 500)));
        // miss all three shots, with an extra trigger ignored in the window
        tbl.push_back(mk(NR,        o(0, 0, 0, 0, 3, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 2, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 2, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 2, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 1, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 1, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 1, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 1, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 0, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 0, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TCK,       o(1, 1, 0, 0, 0, 2, 1, 10'h001, 500)));
        tbl.push_back(mk(TRG,       o(1, 1, 0, 0, 0, 2, 1, 10'h001, 500)));
        tbl.push_back(mk(RSH,       o(0, 1, 0, 0, 3, 2, 1, 10'h001, 500)));
        // reset in the middle of a window, then triggers ignored in IDLE
        tbl.push_back(mk(NR,        o(0, 0, 0, 0, 3, 2, 1, 10'h001, 500)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 2, 2, 1, 10'h001, 500)));
        tbl.push_back(mk(RST,       o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(HIT,       o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(NR,        o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 2, 0, 0, 10'h000, 0)));
        // last shot: hit coincides with the expiring window tick
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 2, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 2, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 1, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 1, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 1, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 0, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TCK,       o(0, 0, 0, 0, 0, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(TCK | HIT, o(0, 0, 1, 0, 0, 1, 1, 10'h001, 500)));
        // new_round dominates trigger and tick: FLY, shots reloaded
        tbl.push_back(mk(NR | TRG | TCK, o(0, 0, 0, 0, 3, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(HIT,       o(0, 0, 0, 0, 3, 1, 1, 10'h001, 500)));
        tbl.push_back(mk(TRG,       o(0, 0, 0, 0, 2, 1, 1, 10'h001, 500)));
        // reset_score beats the same-cycle score increment
        tbl.push_back(mk(HIT | RSC, o(0, 0, 1, 0, 2, 2, 2, 10'h003, 0)));

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].ins, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // ---- fly-away timeout after 300 ticks ---------------------------
        e = o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0);
        applyStimulus(RST, 1'b1, e, "fly.reset");
        applyStimulus(NR,  1'b1, e, "fly.new_round");
        for (int t = 1; t < 300; t++) begin
            applyStimulus(TCK, (t % 50 == 0) || (t == 299), e, $sformatf("fly.tick%0d", t));
        end
        e.fa = 1'b1;
        e.bd = 4'd1;
        applyStimulus(TCK, 1'b1, e, "fly.tick300");

        // ---- trigger on the timeout tick wins, timer then resumes -------
        e = o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0);
        applyStimulus(RST, 1'b1, e, "flytrig.reset");
        applyStimulus(NR,  1'b1, e, "flytrig.new_round");
        for (int t = 1; t < 300; t++) begin
            applyStimulus(TCK, 1'b0, e, "flytrig.tick");
        end
        e.shots = 2'd2;
        applyStimulus(TRG | TCK, 1'b1, e, "flytrig.tick300");
        applyStimulus(TCK, 1'b1, e, "flytrig.win1");
        applyStimulus(TCK, 1'b1, e, "flytrig.win2");
        e.fa = 1'b1;
        e.bd = 4'd1;
        applyStimulus(TCK, 1'b1, e, "flytrig.resume");

        // ---- full game: ten hits, then one past saturation --------------
        e = o(0, 0, 0, 0, 3, 0, 0, 10'h000, 0);
        applyStimulus(RST, 1'b1, e, "game.reset");
        for (int r = 0; r < 11; r++) begin
            e.bs    = 1'b0;
            e.shots = 2'd3;
            applyStimulus(NR, 1'b1, e, $sformatf("game%0d.new_round", r));
            e.shots = 2'd2;
            applyStimulus(TRG, 1'b1, e, $sformatf("game%0d.trigger", r));
            e.bs = 1'b1;
            if (r < 10) begin
                e.bd      = 4'(r + 1);
                e.bh      = 4'(r + 1);
                e.mask[r] = 1'b1;
            end
            e.score = 16'((r + 1) * 500);
            e.go    = (r >= 9);
            applyStimulus(HIT, 1'b1, e, $sformatf("game%0d.hit", r));
        end

        // ---- clear birds and score together ------------------------------
        e = o(0, 0, 1, 0, 2, 0, 0, 10'h000, 0);
        applyStimulus(RB | RSC, 1'b1, e, "game.clear");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
